// File: rtl/contador_mmss_cresc.sv
// Purpose: BCD mm:ss up-counter (00:00..59:59) with load, count enable and saturate-or-wrap end behaviour.
// Latency: one clk edge from load/en to the new count; tc is combinational, done is registered.
// Backpressure: none; en is a plain tick and is ignored while saturated in PARADO.
module contador_mmss_cresc #(
   parameter int WRAP = 0
) (
   input  logic        clk,
   input  logic        clearn,
   input  logic [15:0] data,
   input  logic        load,
   input  logic        en,
   output logic [3:0]  seg_uni,
   output logic [3:0]  seg_dez,
   output logic [3:0]  min_uni,
   output logic [3:0]  min_dez,
   output logic        tc,
   output logic        done
);

   typedef enum logic {
      CONTA  = 1'b0,
      PARADO = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] seg_uni_nxt, seg_dez_nxt, min_uni_nxt, min_dez_nxt;
   logic [3:0] ld_seg_uni, ld_seg_dez, ld_min_uni, ld_min_dez;
   logic       seg_uni_max, seg_dez_max, min_uni_max, min_dez_max;
   logic       at_max;

   // Out-of-range load nibbles are forced to zero, each digit on its own.
   always_comb begin
      ld_min_dez = (data[15:12] > 4'd5) ? 4'd0 : data[15:12];
      ld_min_uni = (data[11:8]  > 4'd9) ? 4'd0 : data[11:8];
      ld_seg_dez = (data[7:4]   > 4'd5) ? 4'd0 : data[7:4];
      ld_seg_uni = (data[3:0]   > 4'd9) ? 4'd0 : data[3:0];
   end

   // Per-digit maximum flags; at_max marks 59:59.
   always_comb begin
      seg_uni_max = (seg_uni == 4'd9);
      seg_dez_max = (seg_dez == 4'd5);
      min_uni_max = (min_uni == 4'd9);
      min_dez_max = (min_dez == 4'd5);
      at_max      = seg_uni_max & seg_dez_max & min_uni_max & min_dez_max;
   end

   // Terminal count warns one cycle ahead of the wrap/saturate edge.
   always_comb begin
      tc = en & load & at_max & (state == CONTA);
   end

   // Next digits and state: load beats en; carries ripple within one edge.
   always_comb begin
      seg_uni_nxt = seg_uni;
      seg_dez_nxt = seg_dez;
      min_uni_nxt = min_uni;
      min_dez_nxt = min_dez;
      state_nxt   = state;
      if (!load) begin
         seg_uni_nxt = ld_seg_uni;
         seg_dez_nxt = ld_seg_dez;
         min_uni_nxt = ld_min_uni;
         min_dez_nxt = ld_min_dez;
         state_nxt   = CONTA;
      end else if (en && (state == CONTA)) begin
         if (at_max && (WRAP == 0)) begin
            state_nxt = PARADO;
         end else begin
            // At 59:59 with wrap, every digit is at max, so all roll to 0.
            seg_uni_nxt = seg_uni_max ? 4'd0 : seg_uni + 4'd1;
            if (seg_uni_max) begin
               seg_dez_nxt = seg_dez_max ? 4'd0 : seg_dez + 4'd1;
            end
            if (seg_uni_max && seg_dez_max) begin
               min_uni_nxt = min_uni_max ? 4'd0 : min_uni + 4'd1;
            end
            if (seg_uni_max && seg_dez_max && min_uni_max) begin
               min_dez_nxt = min_dez_max ? 4'd0 : min_dez + 4'd1;
            end
         end
      end
   end

   // Digit and state registers; clearn aborts to 00:00 / CONTA immediately.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         seg_uni <= 4'd0;
         seg_dez <= 4'd0;
         min_uni <= 4'd0;
         min_dez <= 4'd0;
         state   <= CONTA;
      end else begin
         seg_uni <= seg_uni_nxt;
         seg_dez <= seg_dez_nxt;
         min_uni <= min_uni_nxt;
         min_dez <= min_dez_nxt;
         state   <= state_nxt;
      end
   end

   // done comes straight from the state register.
   always_comb begin
      done = (state == PARADO);
   end

endmodule

// File: tb/tb_contador_mmss_cresc.sv
// Bench for contador_mmss_cresc: one saturating and one wrapping instance share all inputs.
// Reference model keeps elapsed seconds as a plain integer plus a saturated flag per instance.
// Directed scenarios first, then randomized load/en/data with occasional async reset pulses.
module tb_contador_mmss_cresc;

   logic        clk;
   logic        clearn;
   logic [15:0] data;
   logic        load;
   logic        en;

   logic [3:0]  su0, sd0, mu0, md0, su1, sd1, mu1, md1;
   logic        tc0, done0, tc1, done1;

   int n_checks;
   int n_errors;

   int m_secs [2];
   bit m_par  [2];

   contador_mmss_cresc #(.WRAP(0)) dut_sat (
      .clk(clk), .clearn(clearn), .data(data), .load(load), .en(en),
      .seg_uni(su0), .seg_dez(sd0), .min_uni(mu0), .min_dez(md0),
      .tc(tc0), .done(done0)
   );

   contador_mmss_cresc #(.WRAP(1)) dut_wrap (
      .clk(clk), .clearn(clearn), .data(data), .load(load), .en(en),
      .seg_uni(su1), .seg_dez(sd1), .min_uni(mu1), .min_dez(md1),
      .tc(tc1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int load_secs(input logic [15:0] d);
      int md, mu, sd, su;
      md = (int'(d[15:12]) > 5) ? 0 : int'(d[15:12]);
      mu = (int'(d[11:8])  > 9) ? 0 : int'(d[11:8]);
      sd = (int'(d[7:4])   > 5) ? 0 : int'(d[7:4]);
      su = (int'(d[3:0])   > 9) ? 0 : int'(d[3:0]);
      return (md * 10 + mu) * 60 + sd * 10 + su;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_secs[i] = 0;
         m_par[i]  = 1'b0;
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      if (!clearn) return;
      for (int i = 0; i < 2; i++) begin
         if (!load) begin
            m_secs[i] = load_secs(data);
            m_par[i]  = 1'b0;
         end else if (en && !m_par[i]) begin
            if (m_secs[i] == 3599) begin
               if (i == 1) m_secs[i] = 0;
               else        m_par[i]  = 1'b1;
            end else begin
               m_secs[i] = m_secs[i] + 1;
            end
         end
      end
   endtask

   function automatic int exp_tc(input int i);
      return int'(clearn && en && load && (m_secs[i] == 3599) && !m_par[i]);
   endfunction

   task automatic check_all();
      chk("sat_digits",  int'({md0, mu0, sd0, su0}), int'(to_bcd(m_secs[0])));
      chk("sat_done",    int'(done0), int'(m_par[0]));
      chk("sat_tc",      int'(tc0),   exp_tc(0));
      chk("wrap_digits", int'({md1, mu1, sd1, su1}), int'(to_bcd(m_secs[1])));
      chk("wrap_done",   int'(done1), int'(m_par[1]));
      chk("wrap_tc",     int'(tc1),   exp_tc(1));
   endtask

   // Called just after an edge: drive inputs, check the current cycle, take the next edge.
   task automatic apply(input logic ld_n, input logic e, input logic [15:0] d);
      load = ld_n;
      en   = e;
      data = d;
      #1;
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous clearn pulse placed between clock edges.
   task automatic reset_pulse();
      #2;
      clearn = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_now_digits", int'({md0, mu0, sd0, su0}), 0);
      chk("rst_now_done",   int'(done0), 0);
      #1;
      clearn = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clearn = 1'b0;
      load   = 1'b1;
      en     = 1'b0;
      data   = 16'h0000;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #3;
      clearn = 1'b1;
      @(posedge clk);
      #1;

      // Reset pulse between edges, then three ticks.
      apply(1'b1, 1'b1, 16'h0000);
      reset_pulse();
      repeat (3) apply(1'b1, 1'b1, 16'h0000);
      chk("rst_then_3", int'({md0, mu0, sd0, su0}), 16'h0003);

      // Load beats en, then count.
      apply(1'b0, 1'b1, 16'h1234);
      chk("load_prio", int'({md0, mu0, sd0, su0}), 16'h1234);
      apply(1'b1, 1'b1, 16'h0000);
      chk("load_then_en", int'({md0, mu0, sd0, su0}), 16'h1235);

      // Ripple carries and hold.
      apply(1'b0, 1'b0, 16'h0959);
      apply(1'b1, 1'b1, 16'h0000);
      chk("carry_0959", int'({md0, mu0, sd0, su0}), 16'h1000);
      apply(1'b0, 1'b0, 16'h0059);
      apply(1'b1, 1'b1, 16'h0000);
      chk("carry_0059", int'({md0, mu0, sd0, su0}), 16'h0100);
      repeat (5) apply(1'b1, 1'b0, 16'h0000);
      chk("hold", int'({md0, mu0, sd0, su0}), 16'h0100);

      // Saturation vs rollover from 59:58 under continuous en.
      apply(1'b0, 1'b0, 16'h5958);
      apply(1'b1, 1'b1, 16'h0000);
      chk("sat_5959", int'({md0, mu0, sd0, su0}), 16'h5959);
      chk("sat_tc_hi", int'(tc0), 1);
      chk("wrap_tc_hi", int'(tc1), 1);
      apply(1'b1, 1'b1, 16'h0000);
      chk("wrap_0000", int'({md1, mu1, sd1, su1}), 16'h0000);
      chk("wrap_done_lo", int'(done1), 0);
      repeat (10) apply(1'b1, 1'b1, 16'h0000);
      chk("sat_held", int'({md0, mu0, sd0, su0}), 16'h5959);
      chk("sat_done_hi", int'(done0), 1);
      chk("sat_tc_lo", int'(tc0), 0);
      chk("wrap_counting", int'({md1, mu1, sd1, su1}), 16'h0010);

      // Reset while saturated aborts to 00:00.
      reset_pulse();
      apply(1'b1, 1'b1, 16'h0000);
      chk("rst_par_resume", int'({md0, mu0, sd0, su0}), 16'h0001);

      // Leave saturation by load.
      apply(1'b0, 1'b0, 16'h5959);
      repeat (2) apply(1'b1, 1'b1, 16'h0000);
      chk("sat_again", int'(done0), 1);
      apply(1'b0, 1'b0, 16'h0000);
      chk("load_clr_done", int'(done0), 0);
      chk("load_clr_digits", int'({md0, mu0, sd0, su0}), 16'h0000);

      // Invalid nibbles are zeroed independently.
      apply(1'b0, 1'b0, 16'h7A6F);
      chk("inv_load", int'({md0, mu0, sd0, su0}), 16'h0000);
      apply(1'b0, 1'b0, 16'h5959);
      chk("max_load", int'({md0, mu0, sd0, su0}), 16'h5959);
      apply(1'b0, 1'b0, 16'h3C49);
      chk("mixed_load", int'({md0, mu0, sd0, su0}), 16'h3049);

      // Load and en held during reset are ignored.
      clearn = 1'b0;
      model_reset();
      apply(1'b0, 1'b1, 16'h1234);
      chk("rst_blocks_load", int'({md0, mu0, sd0, su0}), 16'h0000);
      #2;
      clearn = 1'b1;

      // Randomized phase.
      for (int k = 0; k < 400; k++) begin
         logic [15:0] d;
         logic        ld_n, e;
         if ($urandom_range(0, 1) == 0)
            d = {4'($urandom_range(4, 5)), 4'($urandom_range(8, 9)),
                 4'($urandom_range(4, 5)), 4'($urandom_range(5, 9))};
         else
            d = 16'($urandom);
         ld_n = ($urandom_range(0, 9) != 0);
         e    = ($urandom_range(0, 9) < 7);
         apply(ld_n, e, d);
         if ($urandom_range(0, 49) == 0) reset_pulse();
      end
      load = 1'b1;
      en   = 1'b0;
      #1;
      check_all();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
